// File: rtl/input_buffer_pkg.sv
// Shared types and constants for the ingress-buffer read scheduler.
// Latency: n/a (types only).
// Backpressure: n/a.
package input_buffer_pkg;

    localparam int NUM_PORTS       = 24;
    localparam int SLICE_ADDR_BITS = 12;
    localparam int PORT_BITS       = 5;

    typedef logic [SLICE_ADDR_BITS-1:0] word_ptr_t;

    // One entry of the read-tag pipeline: travels alongside the cascade read.
    typedef struct packed {
        logic                 valid;
        logic [PORT_BITS-1:0] port;
        logic                 first;
        logic                 last;
    } rd_tag_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

endpackage

// File: rtl/input_buffer_desc_queue.sv
// Per-port descriptor FIFO of frame word counts (DEPTH entries x 12 bits).
// Latency: push visible at head the cycle after; full_o/empty_o are decoded from the registered count.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; zero-length pushes ignored.
//
// Ports: clk_fabric/rst_n clock and async active-low reset; push_i/push_dat_i enqueue a
// word count; pop_i dequeues the head; head_dat_o is the oldest entry; empty_o/full_o status.
module input_buffer_desc_queue
    import input_buffer_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk_fabric,
    input  logic      rst_n,
    input  logic      push_i,
    input  word_ptr_t push_dat_i,
    input  logic      pop_i,
    output word_ptr_t head_dat_o,
    output logic      empty_o,
    output logic      full_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    word_ptr_t     mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        pop_ok  = pop_i && (cnt_q != '0);
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push_ok = push_i && (push_dat_i != '0) && ((cnt_q != FULL_CNT) || pop_ok);
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_fabric or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk_fabric) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_q];
    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);

endmodule

// File: rtl/input_buffer_read_scheduler.sv
// Round-robin read scheduler draining whole frames from the 24-slice cascaded UltraRAM via port B.
// Latency: descriptor to first rd_en is 2 cycles; tags emerge READ_LATENCY cycles after each rd_en.
// Backpressure: 8-bit word-credit counter; rd_en holds low mid-frame while credits are zero.
//
// Ports: frame_push/frame_words enqueue per-port frame lengths, desc_full flags full queues,
// rd_ptr returns per-port consumed pointers, rd_en/rd_addr drive cascade port B, rd_valid is
// the cascade's data-valid, tag_* describe the word on rd_data, credit_return frees one
// downstream slot, tag_mismatch latches any rd_valid/tag disagreement.
module input_buffer_read_scheduler
    import input_buffer_pkg::*;
#(
    parameter int DESC_DEPTH   = 16,
    parameter int READ_LATENCY = 4,
    parameter int OUT_CREDITS  = 32
) (
    input  logic                                          clk_fabric,
    input  logic                                          rst_n,
    input  logic [NUM_PORTS-1:0]                          frame_push,
    input  logic [NUM_PORTS-1:0][SLICE_ADDR_BITS-1:0]     frame_words,
    output logic [NUM_PORTS-1:0]                          desc_full,
    output logic [NUM_PORTS-1:0][SLICE_ADDR_BITS-1:0]     rd_ptr,
    output logic                                          rd_en,
    output logic [PORT_BITS+SLICE_ADDR_BITS-1:0]          rd_addr,
    input  logic                                          rd_valid,
    output logic                                          tag_valid,
    output logic [PORT_BITS-1:0]                          tag_port,
    output logic                                          tag_first,
    output logic                                          tag_last,
    input  logic                                          credit_return,
    output logic                                          tag_mismatch
);

    localparam logic [7:0]           CREDIT_MAX  = 8'(OUT_CREDITS);
    localparam logic [PORT_BITS-1:0] LAST_PORT   = PORT_BITS'(NUM_PORTS - 1);
    localparam logic [PORT_BITS:0]   NUM_PORTS_W = (PORT_BITS+1)'(NUM_PORTS);

    sched_state_t                             state_q, state_d;
    logic [PORT_BITS-1:0]                     port_q, port_d;
    logic [PORT_BITS-1:0]                     rr_q, rr_d;
    word_ptr_t                                ptr_q, ptr_d;
    word_ptr_t                                rem_q, rem_d;
    logic                                     first_q, first_d;
    logic [7:0]                               credits_q, credits_d;
    logic [NUM_PORTS-1:0][SLICE_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    rd_tag_t                                  tag_pipe_q [READ_LATENCY];
    rd_tag_t                                  new_tag;
    logic                                     mismatch_q;

    logic [NUM_PORTS-1:0] q_empty;
    logic [NUM_PORTS-1:0] q_full;
    logic [NUM_PORTS-1:0] q_pop;
    word_ptr_t            q_head [NUM_PORTS];

    logic                 pick_vld;
    logic [PORT_BITS-1:0] pick_port;
    logic                 issue;
    logic                 issue_last;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_queue
        input_buffer_desc_queue #(
            .DEPTH (DESC_DEPTH)
        ) u_desc_queue (
            .clk_fabric (clk_fabric),
            .rst_n      (rst_n),
            .push_i     (frame_push[g]),
            .push_dat_i (frame_words[g]),
            .pop_i      (q_pop[g]),
            .head_dat_o (q_head[g]),
            .empty_o    (q_empty[g]),
            .full_o     (q_full[g])
        );
    end

    // Round-robin pick: first non-empty queue at or after rr_q, wrapping 23 -> 0.
    always_comb begin
        logic [PORT_BITS:0] sum;
        pick_vld  = 1'b0;
        pick_port = '0;
        sum       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = {1'b0, rr_q} + (PORT_BITS+1)'(i);
            if (sum >= NUM_PORTS_W) begin
                sum = sum - NUM_PORTS_W;
            end
            if (!pick_vld && !q_empty[sum[PORT_BITS-1:0]]) begin
                pick_vld  = 1'b1;
                pick_port = sum[PORT_BITS-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        first_d    = first_q;
        rr_d       = rr_q;
        rd_ptr_d   = rd_ptr_q;
        q_pop      = '0;
        issue      = 1'b0;
        issue_last = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    port_d           = pick_port;
                    ptr_d            = rd_ptr_q[pick_port];
                    rem_d            = q_head[pick_port];
                    first_d          = 1'b1;
                    q_pop[pick_port] = 1'b1;
                    state_d          = BURST;
                end
            end
            BURST: begin
                // A frame is never preempted; zero credits simply stall it.
                if (credits_q != '0) begin
                    issue   = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    first_d = 1'b0;
                    if (rem_q == word_ptr_t'(1)) begin
                        issue_last       = 1'b1;
                        rd_ptr_d[port_q] = ptr_q + 1'b1;
                        rr_d             = (port_q == LAST_PORT) ? '0 : port_q + 1'b1;
                        state_d          = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credits_d = credits_q;
        if (issue && !credit_return) begin
            credits_d = credits_q - 1'b1;
        end else if (!issue && credit_return && (credits_q != CREDIT_MAX)) begin
            credits_d = credits_q + 1'b1;
        end
    end

    always_comb begin
        new_tag = '0;
        if (issue) begin
            new_tag.valid = 1'b1;
            new_tag.port  = port_q;
            new_tag.first = first_q;
            new_tag.last  = issue_last;
        end
    end

    always_ff @(posedge clk_fabric or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            port_q     <= '0;
            rr_q       <= '0;
            ptr_q      <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            credits_q  <= CREDIT_MAX;
            rd_ptr_q   <= '0;
            mismatch_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            rr_q       <= rr_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            credits_q  <= credits_d;
            rd_ptr_q   <= rd_ptr_d;
            mismatch_q <= mismatch_q | (rd_valid != tag_pipe_q[READ_LATENCY-1].valid);
            tag_pipe_q[0] <= new_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
        end
    end

    assign rd_en        = issue;
    assign rd_addr      = {port_q, ptr_q};
    assign rd_ptr       = rd_ptr_q;
    assign desc_full    = q_full;
    assign tag_valid    = tag_pipe_q[READ_LATENCY-1].valid;
    assign tag_port     = tag_pipe_q[READ_LATENCY-1].port;
    assign tag_first    = tag_pipe_q[READ_LATENCY-1].first;
    assign tag_last     = tag_pipe_q[READ_LATENCY-1].last;
    assign tag_mismatch = mismatch_q;

endmodule

// File: tb/tb_input_buffer_read_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
// Latency: compares every cycle at the falling edge.
// Backpressure: downstream credits returned by the bench, randomly or per scenario.
module tb_input_buffer_read_scheduler;
    import input_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT   = 4;
    localparam int CRED  = 3;

    logic                        clk_fabric = 1'b0;
    logic                        rst_n      = 1'b0;
    logic [NUM_PORTS-1:0]        frame_push = '0;
    logic [NUM_PORTS-1:0][11:0]  frame_words = '0;
    logic [NUM_PORTS-1:0]        desc_full;
    logic [NUM_PORTS-1:0][11:0]  rd_ptr;
    logic                        rd_en;
    logic [16:0]                 rd_addr;
    logic                        rd_valid = 1'b0;
    logic                        tag_valid;
    logic [4:0]                  tag_port;
    logic                        tag_first;
    logic                        tag_last;
    logic                        credit_return = 1'b0;
    logic                        tag_mismatch;

    always #5 clk_fabric = ~clk_fabric;

    input_buffer_read_scheduler #(
        .DESC_DEPTH   (DEPTH),
        .READ_LATENCY (LAT),
        .OUT_CREDITS  (CRED)
    ) dut (
        .clk_fabric    (clk_fabric),
        .rst_n         (rst_n),
        .frame_push    (frame_push),
        .frame_words   (frame_words),
        .desc_full     (desc_full),
        .rd_ptr        (rd_ptr),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .tag_valid     (tag_valid),
        .tag_port      (tag_port),
        .tag_first     (tag_first),
        .tag_last      (tag_last),
        .credit_return (credit_return),
        .tag_mismatch  (tag_mismatch)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit v;
        int port;
        bit f;
        bit l;
    } etag_t;

    int    mq [NUM_PORTS][$];
    int    m_rdptr [NUM_PORTS];
    int    m_rr;
    bit    m_busy;
    int    m_port, m_ptr, m_rem;
    bit    m_first;
    int    m_cred;
    bit    m_mis;
    etag_t m_pipe [$];

    task automatic model_reset();
        etag_t z;
        z = '{v: 1'b0, port: 0, f: 1'b0, l: 1'b0};
        for (int p = 0; p < NUM_PORTS; p++) begin
            mq[p].delete();
            m_rdptr[p] = 0;
        end
        m_rr = 0; m_busy = 0; m_port = 0; m_ptr = 0; m_rem = 0; m_first = 0;
        m_cred = CRED; m_mis = 0;
        m_pipe.delete();
        for (int i = 0; i < LAT; i++) m_pipe.push_back(z);
    endtask

    // Compare DUT against the model for the current cycle, then advance the model over the edge.
    task automatic evaluate();
        bit    exp_en;
        logic [NUM_PORTS-1:0] exp_full;
        int    rp;
        etag_t nt;
        int    pop_p;
        cyc++;
        if (!rst_n) model_reset();

        exp_en = m_busy && (m_cred > 0);
        check("rd_en", rd_en, exp_en);
        if (exp_en) check("rd_addr", rd_addr, (m_port << 12) | m_ptr);
        check("tag_valid", tag_valid, m_pipe[0].v);
        if (m_pipe[0].v)
            check("tag_fields", {tag_port, tag_first, tag_last},
                  (m_pipe[0].port << 2) | (int'(m_pipe[0].f) << 1) | int'(m_pipe[0].l));
        if (!rst_n) begin
            check("rst_rd_addr", rd_addr, 0);
            check("rst_tag_fields", {tag_port, tag_first, tag_last}, 0);
        end
        for (int p = 0; p < NUM_PORTS; p++) exp_full[p] = (mq[p].size() == DEPTH);
        check("desc_full", desc_full, exp_full);
        rp = cyc % NUM_PORTS;
        check($sformatf("rd_ptr[%0d]", rp), rd_ptr[rp], m_rdptr[rp]);
        check("tag_mismatch", tag_mismatch, m_mis);

        if (!rst_n) return;

        m_mis = m_mis | (rd_valid != m_pipe[0].v);
        nt = '{v: 1'b0, port: 0, f: 1'b0, l: 1'b0};
        if (exp_en) nt = '{v: 1'b1, port: m_port, f: m_first, l: (m_rem == 1)};
        void'(m_pipe.pop_front());
        m_pipe.push_back(nt);

        if (exp_en && !credit_return) m_cred--;
        else if (!exp_en && credit_return && m_cred < CRED) m_cred++;

        pop_p = -1;
        if (exp_en) begin
            m_ptr   = (m_ptr + 1) % 4096;
            m_rem   = m_rem - 1;
            m_first = 0;
            if (m_rem == 0) begin
                m_rdptr[m_port] = m_ptr;
                m_rr   = (m_port + 1) % NUM_PORTS;
                m_busy = 0;
            end
        end else if (!m_busy) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pop_p < 0 && mq[(m_rr + i) % NUM_PORTS].size() > 0) pop_p = (m_rr + i) % NUM_PORTS;
            end
            if (pop_p >= 0) begin
                m_port  = pop_p;
                m_ptr   = m_rdptr[pop_p];
                m_rem   = mq[pop_p].pop_front();
                m_first = 1;
                m_busy  = 1;
            end
        end

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (frame_push[p] && frame_words[p] != 0 && mq[p].size() < DEPTH)
                mq[p].push_back(int'(frame_words[p]));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input logic [NUM_PORTS-1:0] pv, input logic [NUM_PORTS-1:0][11:0] wv,
                         input logic ret, input bit kill_rv);
        @(posedge clk_fabric); #1;
        frame_push    = pv;
        frame_words   = wv;
        credit_return = ret;
        rd_valid      = m_pipe[0].v & ~kill_rv;
        @(negedge clk_fabric);
        evaluate();
    endtask

    task automatic idle(input int n, input logic ret);
        for (int i = 0; i < n; i++) cycle('0, '0, ret, 1'b0);
    endtask

    task automatic push1(input int p, input int w, input logic ret);
        logic [NUM_PORTS-1:0]       pv;
        logic [NUM_PORTS-1:0][11:0] wv;
        pv = '0; wv = '0;
        pv[p] = 1'b1;
        wv[p] = 12'(w);
        cycle(pv, wv, ret, 1'b0);
    endtask

    task automatic random_traffic(input int n);
        logic [NUM_PORTS-1:0]       pv;
        logic [NUM_PORTS-1:0][11:0] wv;
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pv[p] = ($urandom_range(0, 39) == 0);
                wv[p] = 12'($urandom_range(0, 6));
            end
            cycle(pv, wv, ($urandom_range(0, 3) != 0), 1'b0);
        end
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk_fabric); #1;
        rst_n = 1'b0; frame_push = '0; frame_words = '0; credit_return = 1'b0; rd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_fabric);
            evaluate();
            @(posedge clk_fabric); #1;
        end
        rst_n = 1'b1;
        @(negedge clk_fabric);
        evaluate();
    endtask

    initial begin
        logic [NUM_PORTS-1:0]       pv;
        logic [NUM_PORTS-1:0][11:0] wv;
        bit injected;

        model_reset();
        apply_reset(3);

        // Single 5-word frame on port 3.
        push1(3, 5, 1'b1);
        idle(12, 1'b1);

        // Ports 0, 7, 23 together, then 0 and 7 again while the first round drains.
        pv = '0; wv = '0;
        pv[0] = 1'b1; pv[7] = 1'b1; pv[23] = 1'b1;
        wv[0] = 12'd2; wv[7] = 12'd2; wv[23] = 12'd2;
        cycle(pv, wv, 1'b1, 1'b0);
        idle(2, 1'b1);
        pv = '0; pv[0] = 1'b1; pv[7] = 1'b1;
        cycle(pv, wv, 1'b1, 1'b0);
        idle(20, 1'b1);

        // Port 5 slice wrap: advance to 4094, then a 4-word frame crosses 4095 -> 0.
        push1(5, 4094, 1'b1);
        idle(4102, 1'b1);
        push1(5, 4, 1'b1);
        idle(12, 1'b1);

        // Credit stall on a 6-word frame (3 credits).
        push1(2, 6, 1'b0);
        idle(10, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b1);
        idle(6, 1'b0);
        idle(1, 1'b1);
        idle(8, 1'b0);

        // Fill port 9's queue while the scheduler is starved of credits.
        for (int i = 0; i < 18; i++) push1(9, 1, 1'b0);
        idle(3, 1'b0);
        idle(60, 1'b1);

        // Drop rd_valid under a live tag: sticky mismatch.
        push1(4, 3, 1'b1);
        injected = 0;
        for (int i = 0; i < 20; i++) begin
            if (!injected && m_pipe[0].v) begin
                cycle('0, '0, 1'b1, 1'b1);
                injected = 1;
            end else begin
                idle(1, 1'b1);
            end
        end
        if (!injected) check("mismatch_inject_timeout", 32'd0, 32'd1);
        idle(5, 1'b1);

        random_traffic(2500);

        // Reset in the middle of a long burst.
        push1(11, 40, 1'b1);
        idle(10, 1'b1);
        apply_reset(2);
        random_traffic(400);
        idle(200, 1'b1);

        for (int p = 0; p < NUM_PORTS; p++) check($sformatf("final_rd_ptr[%0d]", p), rd_ptr[p], m_rdptr[p]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
